// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: synchronise, debounce on a shared tick, emit level,
// press/release/auto-repeat pulses. The release pulse is named rel because release is a reserved word.
module btn_channel #(
  parameter int   SYNC_STAGES      = 2,
  parameter int   DB_TICKS         = 20,
  parameter int   REP_DELAY_TICKS  = 500,
  parameter int   REP_PERIOD_TICKS = 100,
  parameter logic INV              = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  input  logic rpt_en,
  output logic level,
  output logic level_nxt,
  output logic press,
  output logic rel,
  output logic rpt
);
  localparam int MAXT = (DB_TICKS > REP_DELAY_TICKS) ?
                        ((DB_TICKS > REP_PERIOD_TICKS) ? DB_TICKS : REP_PERIOD_TICKS) :
                        ((REP_DELAY_TICKS > REP_PERIOD_TICKS) ? REP_DELAY_TICKS : REP_PERIOD_TICKS);
  localparam int CW = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REP_DELAY_TICKS - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REP_PERIOD_TICKS - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} st_t;

  st_t                    st;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   ph;
  logic                   s, db_done, acc_press, acc_rel, rep_hit;

  // Sync chain resets to the idle pin level so s starts de-asserted.
  assign s         = sync_q[SYNC_STAGES-1] ^ INV;
  assign db_done   = tick && (cnt == DB_LAST);
  assign acc_press = (st == PRESS_PEND) && s && db_done;
  assign acc_rel   = (st == RELEASE_PEND) && !s && db_done;
  assign level_nxt = acc_press | (level & ~acc_rel);
  assign rep_hit   = tick && (ph ? (cnt == PER_LAST) : (cnt == DLY_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INV}};
      st     <= RELEASED;
      cnt    <= '0;
      ph     <= 1'b0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      rpt    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      level  <= level_nxt;
      press  <= acc_press;
      rel    <= acc_rel;
      rpt    <= 1'b0;
      // A change of s always wins over a tick in the same cycle.
      case (st)
        RELEASED:
          if (s) begin st <= PRESS_PEND; cnt <= '0; end
        PRESS_PEND:
          if (!s)             st  <= RELEASED;
          else if (acc_press) begin st <= PRESSED; cnt <= '0; ph <= 1'b0; end
          else if (tick)      cnt <= cnt + CW'(1);
        PRESSED:
          if (!s)           begin st <= RELEASE_PEND; cnt <= '0; end
          else if (!rpt_en) begin cnt <= '0; ph <= 1'b0; end
          else if (rep_hit) begin rpt <= 1'b1; cnt <= '0; ph <= 1'b1; end
          else if (tick)    cnt <= cnt + CW'(1);
        RELEASE_PEND:
          if (s)            begin st <= PRESSED; cnt <= '0; end
          else if (acc_rel) begin st <= RELEASED; cnt <= '0; end
          else if (tick)    cnt <= cnt + CW'(1);
        default: st <= RELEASED;
      endcase
    end
  end
endmodule

module btn_conditioner #(
  parameter int              N_CH             = 16,
  parameter int              SYNC_STAGES      = 2,
  parameter int              TICK_DIV         = 100000,
  parameter int              DB_TICKS         = 20,
  parameter int              REP_DELAY_TICKS  = 500,
  parameter int              REP_PERIOD_TICKS = 100,
  parameter logic [N_CH-1:0] INVERT           = '0
) (
  input  logic            clk,
  input  logic            sys_rst_n,
  input  logic [N_CH-1:0] raw,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] rpt,
  output logic            any_pressed
);
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]   pre;
  logic            tick;
  logic [N_CH-1:0] level_nxt;

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre         <= '0;
      any_pressed <= 1'b0;
    end else begin
      pre         <= tick ? '0 : pre + PW'(1);
      any_pressed <= |level_nxt;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DB_TICKS         (DB_TICKS),
      .REP_DELAY_TICKS  (REP_DELAY_TICKS),
      .REP_PERIOD_TICKS (REP_PERIOD_TICKS),
      .INV              (INVERT[g])
    ) u_ch (
      .clk       (clk),
      .rst_n     (sys_rst_n),
      .raw       (raw[g]),
      .tick      (tick),
      .rpt_en    (repeat_en[g]),
      .level     (level[g]),
      .level_nxt (level_nxt[g]),
      .press     (press[g]),
      .rel       (rel[g]),
      .rpt       (rpt[g])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: pulse scoreboard with cycle windows plus level checks.
module tb_btn_conditioner;
  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic [3:0] raw, repeat_en, level, press, rel, rpt;
  logic       any_pressed;

  btn_conditioner #(
    .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(4), .DB_TICKS(3),
    .REP_DELAY_TICKS(5), .REP_PERIOD_TICKS(2), .INVERT(4'b1000)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .raw(raw), .repeat_en(repeat_en),
    .level(level), .press(press), .rel(rel), .rpt(rpt), .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = press, 1 = release, 2 = repeat
  typedef struct {int ch; int kind; int lo; int hi;} exp_t;
  exp_t sb[$];
  int   obs_cnt [4][3];
  int   last_cyc[4][3];
  int   idx;
  logic p;

  always @(negedge clk) begin
    if (sys_rst_n) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 3; k++) begin
          p = (k == 0) ? press[c] : (k == 1) ? rel[c] : rpt[c];
          if (p) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
              if (idx < 0 && sb[i].ch == c && sb[i].kind == k) idx = i;
            chk($sformatf("pulse_expected ch%0d kind%0d cyc%0d", c, k, cyc), 32'(idx >= 0), 1);
            if (idx >= 0) begin
              chk($sformatf("pulse_cycle ch%0d kind%0d at %0d window %0d..%0d",
                            c, k, cyc, sb[idx].lo, sb[idx].hi),
                  32'(cyc >= sb[idx].lo && cyc <= sb[idx].hi), 1);
              sb.delete(idx);
            end
            if (k < 2) chk($sformatf("level_at_pulse ch%0d kind%0d", c, k), 32'(level[c]), 32'(k == 0));
            obs_cnt[c][k]++;
            last_cyc[c][k] = cyc;
          end
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].hi < cyc) begin
          chk($sformatf("pulse_missing ch%0d kind%0d", sb[i].ch, sb[i].kind), cyc, sb[i].hi);
          sb.delete(i);
        end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic expect_pulse(input int ch, input int k, input int lo, input int hi);
    exp_t e;
    e.ch = ch; e.kind = k; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic wait_pulse(input int ch, input int k, input int bound);
    int n0;
    int i;
    n0 = obs_cnt[ch][k];
    i  = 0;
    while (obs_cnt[ch][k] == n0 && i < bound) begin step(1); i++; end
    chk($sformatf("wait ch%0d kind%0d", ch, k), 32'(obs_cnt[ch][k] != n0), 1);
  endtask

  int c0, r, d, pc;

  initial begin
    sys_rst_n = 1'b0;
    raw       = 4'b1000;
    repeat_en = 4'b0000;
    step(3);
    chk("rst_level", level, 0);
    chk("rst_press", press, 0);
    chk("rst_rel", rel, 0);
    chk("rst_rpt", rpt, 0);
    chk("rst_any", any_pressed, 0);
    sys_rst_n = 1'b1;
    step(20);
    chk("idle_level", level, 0);
    chk("idle_any", any_pressed, 0);

    // clean press on ch0, no repeat while repeat_en is low
    c0 = cyc; raw[0] = 1'b1;
    expect_pulse(0, 0, c0 + 12, c0 + 15);
    wait_pulse(0, 0, 20);
    chk("press_level", level, 4'b0001);
    chk("press_any", any_pressed, 1);
    chk("press_onehot", press, 4'b0001);
    step(30);
    chk("ch0_press_count", obs_cnt[0][0], 1);

    // enable repeat, then a short release bounce must keep the period phase
    c0 = cyc; repeat_en[0] = 1'b1;
    expect_pulse(0, 2, c0 + 17, c0 + 20);
    wait_pulse(0, 2, 25);
    r = last_cyc[0][2];
    expect_pulse(0, 2, r + 8, r + 8);
    wait_pulse(0, 2, 12);
    d = cyc; raw[0] = 1'b0;
    step(6);
    raw[0] = 1'b1;
    expect_pulse(0, 2, d + 14, d + 17);
    wait_pulse(0, 2, 25);
    repeat_en[0] = 1'b0;
    step(40);
    chk("ch0_rpt_count", obs_cnt[0][2], 3);
    chk("ch0_no_release", obs_cnt[0][1], 0);
    chk("ch0_still_level", level, 4'b0001);

    // bounce on ch1 never settles long enough
    for (int i = 0; i < 12; i++) begin raw[1] = ~raw[1]; step(5); end
    step(20);
    chk("bounce_level", level, 4'b0001);
    chk("bounce_press", obs_cnt[1][0], 0);
    chk("bounce_rel", obs_cnt[1][1], 0);

    // auto-repeat on ch2
    repeat_en[2] = 1'b1;
    c0 = cyc; raw[2] = 1'b1;
    expect_pulse(2, 0, c0 + 12, c0 + 15);
    wait_pulse(2, 0, 20);
    pc = last_cyc[2][0];
    for (int j = 0; j < 10; j++) expect_pulse(2, 2, pc + 20 + 8 * j, pc + 20 + 8 * j);
    step(pc + 94 - cyc);
    c0 = cyc; raw[2] = 1'b0;
    expect_pulse(2, 1, c0 + 12, c0 + 15);
    wait_pulse(2, 1, 20);
    repeat_en[2] = 1'b0;
    chk("ch2_rpt_count", obs_cnt[2][2], 10);
    chk("ch2_released", level, 4'b0001);

    // active-low ch3
    c0 = cyc; raw[3] = 1'b0;
    expect_pulse(3, 0, c0 + 12, c0 + 15);
    wait_pulse(3, 0, 20);
    chk("ch3_level", level, 4'b1001);
    c0 = cyc; raw[3] = 1'b1;
    expect_pulse(3, 1, c0 + 12, c0 + 15);
    wait_pulse(3, 1, 20);
    chk("ch3_released", level, 4'b0001);
    chk("sb_empty_pre_rst", sb.size(), 0);

    // reset while ch0 is held
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_level", level, 0);
    chk("midrst_any", any_pressed, 0);
    chk("midrst_pulses", {press, rel, rpt}, 0);
    step(3);
    c0 = cyc; sys_rst_n = 1'b1;
    expect_pulse(0, 0, c0 + 12, c0 + 15);
    wait_pulse(0, 0, 20);
    chk("postrst_level", level, 4'b0001);
    chk("postrst_any", any_pressed, 1);
    step(5);
    chk("sb_empty_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
